// File: rtl/bus_pkg.sv
// bus_pkg: line/word geometry, line-address slice and FSM states shared by the line bus responder.
package bus_pkg;
  localparam int LINE_W = 512;
  localparam int WORD_W = 32;
  localparam int BEATS = 16;
  localparam int LINE_MSB = 31;
  localparam int LINE_LSB = 6;
  localparam int LINE_AW = LINE_MSB - LINE_LSB + 1;
  typedef enum logic [1:0] {IDLE, RD_XFER, WR_XFER, DONE} state_t;
endpackage

// File: rtl/line_beat_buffer.sv
// line_beat_buffer: 512-bit line register with full-line load, beat-indexed word write and word read.
module line_beat_buffer
  import bus_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [LINE_W-1:0] load_data,
  input  logic              we,
  input  logic [3:0]        idx,
  input  logic [WORD_W-1:0] wdata,
  output logic [WORD_W-1:0] rdata,
  output logic [LINE_W-1:0] q
);
  always_ff @(posedge clk)
    if (!rst_n) q <= '0;
    else if (load) q <= load_data;
    else if (we) q[idx*WORD_W +: WORD_W] <= wdata;
  assign rdata = q[idx*WORD_W +: WORD_W];
endmodule

// File: rtl/line_bus_responder.sv
// line_bus_responder: bridges 512-bit CPU line reads/writes onto a 32-bit beat-acked memory port.
// Optional LINE_FWD_EN adds a one-line write buffer that serves matching reads without memory.
module line_bus_responder
  import bus_pkg::*;
#(
  parameter logic [31:0] MEM_BASE = 32'h0000_0000,
  parameter int LINE_WORDS = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              busRead,
  input  logic              busWrite,
  input  logic [31:0]       busAddr,
  input  logic [LINE_W-1:0] busIn,
  output logic [LINE_W-1:0] busOut,
  output logic              busRdy,
  output logic [31:0]       memAddr,
  output logic [WORD_W-1:0] memWrData,
  input  logic [WORD_W-1:0] memRdData,
  output logic              memRd,
  output logic              memWr,
  input  logic              memAck
);
  state_t state, nxt;
  logic [LINE_AW-1:0] line;
  logic [3:0] cnt;
  logic rd_pend, accept, ack_beat, last, hit, out_load;
  logic [LINE_W-1:0] wline, out_data;
  logic [WORD_W-1:0] wword, out_word;
  logic unused_ok;
  assign accept = state == IDLE && (busRead || busWrite);
  assign memRd = state == RD_XFER;
  assign memWr = state == WR_XFER;
  assign busRdy = state == DONE;
  assign ack_beat = memAck && (memRd || memWr);
  assign last = ack_beat && cnt == 4'(LINE_WORDS - 1);
  assign memAddr = (memRd || memWr) ? MEM_BASE + {line, cnt, 2'b00} : '0;
  assign memWrData = memWr ? wword : '0;
  // a combined request runs its write first and chains straight into the read
  always_comb
    nxt = state == IDLE ? (busWrite ? WR_XFER : busRead ? (hit ? DONE : RD_XFER) : IDLE)
        : state == DONE ? IDLE
        : !last ? state
        : (state == WR_XFER && rd_pend) ? RD_XFER : DONE;
  always_ff @(posedge clk)
    if (!rst_n) begin
      state <= IDLE;
      line <= '0;
      cnt <= '0;
      rd_pend <= 1'b0;
    end else begin
      state <= nxt;
      if (accept) begin
        line <= busAddr[LINE_MSB:LINE_LSB];
        cnt <= '0;
        rd_pend <= busRead;
      end else if (ack_beat) cnt <= cnt + 4'd1;
    end
  line_beat_buffer u_wline (
    .clk(clk), .rst_n(rst_n), .load(accept), .load_data(busIn),
    .we(1'b0), .idx(cnt), .wdata('0), .rdata(wword), .q(wline)
  );
  line_beat_buffer u_out (
    .clk(clk), .rst_n(rst_n), .load(out_load), .load_data(out_data),
    .we(memRd && memAck), .idx(cnt), .wdata(memRdData), .rdata(out_word), .q(busOut)
  );
`ifdef LINE_FWD_EN
  logic fwd_valid;
  logic [LINE_AW-1:0] fwd_line;
  logic [WORD_W-1:0] unused_fwd_word;
  assign hit = fwd_valid && fwd_line == busAddr[LINE_MSB:LINE_LSB];
  assign out_load = state == IDLE && busRead && !busWrite && hit;
  always_ff @(posedge clk)
    if (!rst_n) begin
      fwd_valid <= 1'b0;
      fwd_line <= '0;
    end else if (memWr && last) begin
      fwd_valid <= 1'b1;
      fwd_line <= line;
    end
  line_beat_buffer u_fwd (
    .clk(clk), .rst_n(rst_n), .load(memWr && last), .load_data(wline),
    .we(1'b0), .idx(cnt), .wdata('0), .rdata(unused_fwd_word), .q(out_data)
  );
`else
  assign hit = 1'b0;
  assign out_load = 1'b0;
  assign out_data = '0;
`endif
  assign unused_ok = ^{busAddr[LINE_LSB-1:0], out_word, wline};
endmodule

// File: tb/tb_line_bus_responder.sv
// tb_line_bus_responder: directed vectors against a beat-level memory model with configurable ack rate.
module tb_line_bus_responder;
  logic clk = 0, rst_n = 0, busRead = 0, busWrite = 0, ack_all = 1;
  logic memAck, memRd, memWr, busRdy;
  logic [31:0] busAddr = 0, memAddr, memWrData, memRdData;
  logic [511:0] busIn = 0, busOut;
  logic [1:0] ack_div = 0;
  logic [31:0] wm [0:1023];
  logic [1023:0] wv = '0;
  int total = 0, bad = 0, rdy_cnt = 0, rd_beats = 0, wr_beats = 0, both_hi = 0;

  always #5 clk = ~clk;

  line_bus_responder dut (
    .clk(clk), .rst_n(rst_n), .busRead(busRead), .busWrite(busWrite), .busAddr(busAddr),
    .busIn(busIn), .busOut(busOut), .busRdy(busRdy), .memAddr(memAddr), .memWrData(memWrData),
    .memRdData(memRdData), .memRd(memRd), .memWr(memWr), .memAck(memAck)
  );

  assign memAck = ack_all | (ack_div == 2'd2);
  assign memRdData = wv[memAddr[11:2]] ? wm[memAddr[11:2]] : (32'hC0DE_0000 | {22'd0, memAddr[11:2]});

  always @(posedge clk) begin
    ack_div <= (memRd || memWr) ? (ack_div == 2'd2 ? 2'd0 : ack_div + 2'd1) : 2'd0;
    if (memWr && memAck) begin
      wm[memAddr[11:2]] <= memWrData;
      wv[memAddr[11:2]] <= 1'b1;
    end
    if (busRdy) rdy_cnt <= rdy_cnt + 1;
    if (memRd && memAck) rd_beats <= rd_beats + 1;
    if (memWr && memAck) wr_beats <= wr_beats + 1;
    if (memRd && memWr) both_hi <= both_hi + 1;
  end

  task automatic chk(input string tag, input logic [511:0] got, input logic [511:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [511:0] pat(input logic [31:0] b, input logic [31:0] s);
    logic [511:0] p;
    for (int k = 0; k < 16; k++) p[k*32 +: 32] = b + k * s;
    return p;
  endfunction

  task automatic issue(input logic rd, input logic wr, input logic [31:0] a, input logic [511:0] d);
    @(negedge clk);
    busRead = rd;
    busWrite = wr;
    busAddr = a;
    busIn = d;
    @(posedge clk);
    #1;
    busRead = 0;
    busWrite = 0;
    busIn = '0;
  endtask

  task automatic xfer(input logic [31:0] a, input logic [511:0] wd, input logic want_wr, output int lat);
    int wb, rb;
    wb = 0;
    rb = 0;
    lat = 0;
    for (int c = 1; c <= 200 && lat == 0; c++) begin
      @(negedge clk);
      if (busRdy) lat = c;
      else if (memWr) begin
        chk("wr_addr", memAddr, a + 4 * wb);
        chk("wr_data", memWrData, wd[wb*32 +: 32]);
        if (memAck) wb++;
      end else if (memRd) begin
        chk("rd_order", wb, want_wr ? 16 : 0);
        chk("rd_addr", memAddr, a + 4 * rb);
        if (memAck) rb++;
      end
    end
    if (lat == 0) chk("rdy_timeout", 0, 1);
    @(negedge clk);
    chk("rdy_pulse", busRdy, 0);
  endtask

  initial begin
    int lat, r0, w0, y0;
    logic found;
    repeat (3) @(negedge clk);
    chk("rst_rdy", busRdy, 0);
    chk("rst_rd", memRd, 0);
    chk("rst_wr", memWr, 0);
    chk("rst_addr", memAddr, 0);
    chk("rst_wdata", memWrData, 0);
    chk("rst_out", busOut, 0);
    rst_n = 1;

    r0 = rd_beats; y0 = rdy_cnt;
    issue(1, 0, 32'h40, '0);
    xfer(32'h40, '0, 0, lat);
    chk("rd40_lat", lat, 17);
    chk("rd40_line", busOut, pat(32'hC0DE_0010, 1));
    chk("rd40_beats", rd_beats - r0, 16);
    chk("rd40_rdy", rdy_cnt - y0, 1);

    r0 = rd_beats; w0 = wr_beats; y0 = rdy_cnt;
    issue(0, 1, 32'h80, pat(32'hA0, 1));
    xfer(32'h80, pat(32'hA0, 1), 0, lat);
    chk("wr80_lat", lat, 17);
    chk("wr80_out_kept", busOut, pat(32'hC0DE_0010, 1));
    chk("wr80_beats", wr_beats - w0, 16);
    chk("wr80_no_rd", rd_beats - r0, 0);
    chk("wr80_rdy", rdy_cnt - y0, 1);

    ack_all = 0;
    issue(1, 0, 32'hC0, '0);
    xfer(32'hC0, '0, 0, lat);
    chk("slow_lat", lat, 49);
    chk("slow_line", busOut, pat(32'hC0DE_0030, 1));
    ack_all = 1;

    r0 = rd_beats; w0 = wr_beats; y0 = rdy_cnt;
    issue(1, 1, 32'h100, pat(32'h5000_0000, 32'h11));
    xfer(32'h100, pat(32'h5000_0000, 32'h11), 1, lat);
    chk("both_lat", lat, 33);
    chk("both_line", busOut, pat(32'h5000_0000, 32'h11));
    chk("both_wr", wr_beats - w0, 16);
    chk("both_rd", rd_beats - r0, 16);
    chk("both_rdy", rdy_cnt - y0, 1);

    issue(1, 0, 32'h40, '0);
    found = 0;
    for (int c = 0; c < 40 && !found; c++) begin
      @(negedge clk);
      if (memRd && memAddr == 32'h5C) found = 1;
    end
    chk("beat7_seen", found, 1);
    rst_n = 0;
    y0 = rdy_cnt;
    @(negedge clk);
    chk("abort_rd", memRd, 0);
    chk("abort_wr", memWr, 0);
    chk("abort_rdy", busRdy, 0);
    chk("abort_out", busOut, 0);
    rst_n = 1;
    repeat (20) @(negedge clk);
    chk("abort_no_rdy", rdy_cnt - y0, 0);
    issue(1, 0, 32'h40, '0);
    xfer(32'h40, '0, 0, lat);
    chk("post_rst_lat", lat, 17);
    chk("post_rst_line", busOut, pat(32'hC0DE_0010, 1));

    issue(0, 1, 32'h200, pat(32'h7700_0000, 3));
    xfer(32'h200, pat(32'h7700_0000, 3), 0, lat);
    chk("wr200_lat", lat, 17);
    r0 = rd_beats;
    issue(1, 0, 32'h200, '0);
    xfer(32'h200, '0, 0, lat);
    chk("rd200_line", busOut, pat(32'h7700_0000, 3));
`ifdef LINE_FWD_EN
    chk("fwd_lat", lat, 1);
    chk("fwd_no_rd", rd_beats - r0, 0);
    r0 = rd_beats;
    issue(1, 0, 32'h240, '0);
    xfer(32'h240, '0, 0, lat);
    chk("miss_lat", lat, 17);
    chk("miss_rd", rd_beats - r0, 16);
    chk("miss_line", busOut, pat(32'hC0DE_0090, 1));
`else
    chk("rd200_lat", lat, 17);
    chk("rd200_rd", rd_beats - r0, 16);
`endif
    chk("strobe_excl", both_hi, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/line_bus_responder.md
LINE_BUS_RESPONDER -- requirements
Module: line_bus_responder

Interface
REQ-001 Parameter: MEM_BASE, 32'h0000_0000, byte offset added to every memAddr issued.
REQ-002 Parameter: LINE_WORDS, 16, 32-bit words per 512-bit line; only 16 is supported.
REQ-003 clk  input  1  sole clock; all logic on posedge.
REQ-004 rst_n  input  1  reset; synchronous, active-low.
REQ-005 busRead  input  1  CPU line-read request.
REQ-006 busWrite  input  1  CPU line-write request.
REQ-007 busAddr  input  32  CPU byte address; line = busAddr[31:6].
REQ-008 busIn  input  512  CPU write line; word k = bits [32k+31:32k].
REQ-009 busOut  output  512  read line returned to CPU.
REQ-010 busRdy  output  1  one-cycle completion pulse for either request type.
REQ-011 memAddr  output  32  narrow-memory byte address.
REQ-012 memWrData  output  32  narrow-memory write word.
REQ-013 memRdData  input  32  narrow-memory read word.
REQ-014 memRd, memWr  output  1 each  beat request strobes; never both high.
REQ-015 memAck  input  1  beat complete when sampled high with memRd or memWr.

Function
REQ-016 FSM states: IDLE, RD_XFER, WR_XFER, DONE.
REQ-017 Requests are sampled only in IDLE; busRead/busWrite in other states are ignored, so the initiator must hold off until busRdy.
REQ-018 On acceptance, busAddr[31:6] and busIn are latched, beat counter = 0.
REQ-019 busRead and busWrite both high in IDLE: write is serviced first, then the read executes with no return to IDLE; only one busRdy pulse, after the read.
REQ-020 Beat k address = MEM_BASE + {line, k[3:0], 2'b00}; beats issue in order 0..15.
REQ-021 memRd/memWr, memAddr and memWrData stay stable until memAck; on ack the next beat is presented the following cycle with no idle gap.
REQ-022 Read beat k stores memRdData into busOut word k on its ack cycle.
REQ-023 Ack of beat 15 -> DONE; DONE drives busRdy=1 for exactly one cycle, then IDLE.
REQ-024 Latency with memAck tied high: request sampled at edge T, beats occupy cycles T+1..T+16, busRdy high in cycle T+17.
REQ-025 busOut holds the last completed read line until the next read finishes; a write leaves busOut unchanged.
REQ-026 Beat counter wraps 15->0 only via DONE; no partial-line transfers.

Reset
REQ-027 rst_n low at an edge: state IDLE; busRdy, memRd, memWr = 0; memAddr, memWrData, busOut = 0; forward buffer invalid.
REQ-028 Reset mid-transfer aborts the line: strobes drop at that edge, no busRdy is produced, and partial read data is discarded (busOut is zero).

Configuration
REQ-029 Macro LINE_FWD_EN: a one-line buffer keeps the last written line and its address, marked valid on write completion.
REQ-030 With LINE_FWD_EN, a read whose line matches the valid buffer bypasses memory: IDLE -> DONE, busOut = buffered line, busRdy in cycle T+1, no memRd.
REQ-031 Without LINE_FWD_EN, every read goes to memory and no buffer storage exists.

Structure
REQ-032 Package bus_pkg holds LINE_W=512, WORD_W=32, BEATS=16, the state enum and the line-address slice constants.
REQ-033 One sub-module, line_beat_buffer: 512-bit register with beat-indexed word write and word read, used for busOut and the forward buffer.

Verification
REQ-034 memAck=1; busRead addr 0x0000_0040 -> memAddr 0x40,0x44..0x7C on consecutive cycles; busRdy at T+17; busOut word k = mem[0x40+4k].
REQ-035 busWrite addr 0x80, word k = k+0xA0 -> 16 memWr beats with memWrData 0xA0..0xAF; busRdy once; busOut unchanged.
REQ-036 memAck high only every 3rd cycle -> strobes, addr and data held between acks; busRdy at T+1+48.
REQ-037 busRead and busWrite together, addr 0x100 -> 16 writes then 16 reads, read data equals written data, single busRdy.
REQ-038 rst_n low at beat 7 of a read -> strobes 0 next cycle, no busRdy, busOut 0; a new read after reset completes normally.
REQ-039 LINE_FWD_EN: write 0x200, then read 0x200 -> no memRd, busRdy at T+1 with written line; read 0x240 -> normal memory path.
